// File: rtl/sd_pio_pkg.sv
// Shared constants and helpers for the SD bit-bang input port.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sd_pio_pkg;

   // Word addresses of the register map
   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   // Which transitions of a synchronised pad bit count as an edge
   typedef enum logic [1:0] {
      EDGE_RISE = 2'd0,
      EDGE_FALL = 2'd1,
      EDGE_ANY  = 2'd2
   } edge_type_e;

   // Per-bit edge detector from the current and previous synchronised level
   function automatic logic edge_bit(edge_type_e kind, logic cur, logic prv);
      case (kind)
         EDGE_RISE: return cur & ~prv;
         EDGE_FALL: return ~cur & prv;
         default:   return cur ^ prv;
      endcase
   endfunction

endpackage

// File: rtl/sd_dat_in_port_if.sv
// Avalon-MM slave bus bundle for the SD DAT/CMD input port.
// Latency: wires only; readdata is registered inside the slave (1 clock).
// Backpressure: none; the slave never stalls (no waitrequest).
interface sd_dat_in_port_if #(
   parameter int WIDTH = 4
);
   logic [1:0]       address;
   logic             chipselect;
   logic             read_n;
   logic             write_n;
   logic [WIDTH-1:0] writedata;
   logic [WIDTH-1:0] readdata;
   logic             irq;

   modport master (
      output address, chipselect, read_n, write_n, writedata,
      input  readdata, irq
   );

   modport slave (
      input  address, chipselect, read_n, write_n, writedata,
      output readdata, irq
   );
endinterface

// File: rtl/sd_pio_sync.sv
// Multi-flop synchroniser for WIDTH independent asynchronous pad bits.
// Latency: SYNC_STAGES clocks from pad to q.
// Backpressure: none; samples every clock.
module sd_pio_sync #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [SYNC_STAGES];

   // Shift the pad levels down the flop chain; reset clears every stage
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= d;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/sd_dat_in_port.sv
// SD DAT/CMD pad sampler with sticky edge capture for bit-bang reads; SD_PIO_IRQ_EN adds IRQMASK and irq.
// Latency: pad->DATA SYNC_STAGES clocks; read data 1 clock after request; irq 1 clock after capture.
// Backpressure: none; every access completes immediately, no wait states.
module sd_dat_in_port
   import sd_pio_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_port,
   sd_dat_in_port_if.slave  bus
);

   localparam edge_type_e EDGE_SEL  = edge_type_e'(EDGE_TYPE[1:0]);
   // Enough cycles for reset-cleared synchroniser and prev flops to refill
   localparam logic [2:0] ARM_MAX   = 3'(SYNC_STAGES + 1);

   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] edgecap;
   logic [WIDTH-1:0] w1c;
   logic [WIDTH-1:0] mask_rd;
   logic [WIDTH-1:0] rd_mux;
   logic [WIDTH-1:0] readdata_q;
   logic [2:0]       arm_cnt;
   logic             armed;
   logic             rd_req;
   logic             wr_req;

   sd_pio_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (in_port),
      .q       (sync)
   );

   // A simultaneous read and write performs only the write
   assign rd_req = bus.chipselect & ~bus.read_n & bus.write_n;
   assign wr_req = bus.chipselect & ~bus.write_n;
   assign w1c    = (wr_req && (bus.address == ADDR_EDGECAP)) ? bus.writedata : '0;
   assign armed  = (arm_cnt == ARM_MAX);

   // Track previous level and count up to the armed state after reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         prev    <= '0;
         arm_cnt <= '0;
      end else begin
         prev <= sync;
         if (!armed) begin
            arm_cnt <= arm_cnt + 3'd1;
         end
      end
   end

   // Per-bit edge detection, suppressed until the pipeline holds real pad data
   always_comb begin
      edge_det = '0;
      for (int i = 0; i < WIDTH; i++) begin
         edge_det[i] = armed & edge_bit(EDGE_SEL, sync[i], prev[i]);
      end
   end

   // Sticky capture: write-one-to-clear, a new edge overrides its own clear
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         edgecap <= '0;
      end else begin
         edgecap <= (edgecap & ~w1c) | edge_det;
      end
   end

`ifdef SD_PIO_IRQ_EN
   logic [WIDTH-1:0] irqmask;
   logic             irq_q;

   // Interrupt mask register and registered level interrupt
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         irqmask <= '0;
         irq_q   <= 1'b0;
      end else begin
         if (wr_req && (bus.address == ADDR_IRQMASK)) begin
            irqmask <= bus.writedata;
         end
         irq_q <= |(edgecap & irqmask);
      end
   end

   assign mask_rd = irqmask;
   assign bus.irq = irq_q;
`else
   // Polling-only build: mask reads as zero and the interrupt never fires
   assign mask_rd = '0;
   assign bus.irq = 1'b0;
`endif

   // Read decode from the request cycle's address
   always_comb begin
      rd_mux = '0;
      case (bus.address)
         ADDR_DATA:    rd_mux = sync;
         ADDR_IRQMASK: rd_mux = mask_rd;
         ADDR_EDGECAP: rd_mux = edgecap;
         default:      rd_mux = '0;
      endcase
   end

   // Registered read data, held between read requests
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         readdata_q <= '0;
      end else if (rd_req) begin
         readdata_q <= rd_mux;
      end
   end

   assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_sd_dat_in_port.sv
// Bench for sd_dat_in_port: a falling-edge and an any-edge instance share pads and bus stimulus.
// Latency: checks readdata one clock after each request and irq one clock after capture.
// Backpressure: n/a; the DUT never stalls.
module tb_sd_dat_in_port;

   localparam int SS = 2;
`ifdef SD_PIO_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] in_port;
   logic [1:0] address;
   logic       cs;
   logic       rd_n;
   logic       wr_n;
   logic [3:0] wdata;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   always #5 clk = ~clk;

   sd_dat_in_port_if #(.WIDTH(4)) bus_f ();
   sd_dat_in_port_if #(.WIDTH(4)) bus_a ();

   assign bus_f.address    = address;
   assign bus_f.chipselect = cs;
   assign bus_f.read_n     = rd_n;
   assign bus_f.write_n    = wr_n;
   assign bus_f.writedata  = wdata;
   assign bus_a.address    = address;
   assign bus_a.chipselect = cs;
   assign bus_a.read_n     = rd_n;
   assign bus_a.write_n    = wr_n;
   assign bus_a.writedata  = wdata;

   sd_dat_in_port #(.WIDTH(4), .SYNC_STAGES(SS), .EDGE_TYPE(1)) u_fall (
      .clk     (clk),
      .reset_n (reset_n),
      .in_port (in_port),
      .bus     (bus_f)
   );

   sd_dat_in_port #(.WIDTH(4), .SYNC_STAGES(SS), .EDGE_TYPE(2)) u_any (
      .clk     (clk),
      .reset_n (reset_n),
      .in_port (in_port),
      .bus     (bus_a)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // Index 0 = falling-edge instance, index 1 = any-edge instance
   int          edge_kind [2] = '{1, 2};
   logic [3:0]  hist [$];
   logic [3:0]  sync_m, prev_m, mask_m;
   logic [3:0]  ecap_m [2];
   logic [3:0]  rd_m   [2];
   logic        irq_m  [2];
   int          since_rst;
   bit          model_ok = 1'b0;

   function automatic logic [3:0] model_edges(int kind, logic [3:0] cur, logic [3:0] pv);
      case (kind)
         0:       return cur & ~pv;
         1:       return ~cur & pv;
         default: return cur ^ pv;
      endcase
   endfunction

   function automatic logic [3:0] read_model(int d, logic [1:0] a, logic [3:0] cur);
      case (a)
         2'd0:    return cur;
         2'd2:    return IRQ_EN ? mask_m : 4'h0;
         2'd3:    return ecap_m[d];
         default: return 4'h0;
      endcase
   endfunction

   always @(posedge clk) begin
      logic [3:0] cur, pv, e, w1c;
      bit         armed, rd, wr;
      if (!reset_n) begin
         hist.delete();
         sync_m    = 4'h0;
         prev_m    = 4'h0;
         mask_m    = 4'h0;
         since_rst = 0;
         for (int d = 0; d < 2; d++) begin
            ecap_m[d] = 4'h0;
            rd_m[d]   = 4'h0;
            irq_m[d]  = 1'b0;
         end
         model_ok = 1'b1;
      end else begin
         cur   = sync_m;
         pv    = prev_m;
         armed = (since_rst >= SS + 1);
         rd    = cs && !rd_n && wr_n;
         wr    = cs && !wr_n;
         w1c   = (wr && address == 2'd3) ? wdata : 4'h0;
         for (int d = 0; d < 2; d++) begin
            if (rd) rd_m[d] = read_model(d, address, cur);
            irq_m[d]  = IRQ_EN ? |(ecap_m[d] & mask_m) : 1'b0;
            e         = armed ? model_edges(edge_kind[d], cur, pv) : 4'h0;
            ecap_m[d] = (ecap_m[d] & ~w1c) | e;
         end
         if (IRQ_EN && wr && address == 2'd2) mask_m = wdata;
         prev_m = cur;
         hist.push_back(in_port);
         if (hist.size() > SS) void'(hist.pop_front());
         sync_m = (hist.size() == SS) ? hist[0] : 4'h0;
         since_rst++;
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (model_ok) begin
         check("cyc_rd_fall",  bus_f.readdata, rd_m[0]);
         check("cyc_rd_any",   bus_a.readdata, rd_m[1]);
         check("cyc_irq_fall", bus_f.irq,      irq_m[0]);
         check("cyc_irq_any",  bus_a.irq,      irq_m[1]);
      end
   end

   // ---------------- bus tasks (called at a falling edge) ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [3:0] rf, output logic [3:0] ra);
      address = a; cs = 1'b1; rd_n = 1'b0;
      @(negedge clk);
      cs = 1'b0; rd_n = 1'b1;
      rf = bus_f.readdata;
      ra = bus_a.readdata;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [3:0] dat);
      address = a; wdata = dat; cs = 1'b1; wr_n = 1'b0;
      @(negedge clk);
      cs = 1'b0; wr_n = 1'b1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [3:0] rf, ra;
      reset_n = 1'b0; in_port = 4'hF; address = 2'd0;
      cs = 1'b0; rd_n = 1'b1; wr_n = 1'b1; wdata = 4'h0;
      tick(3);
      check("rst_rd_fall",  bus_f.readdata, 4'h0);
      check("rst_rd_any",   bus_a.readdata, 4'h0);
      check("rst_irq_fall", bus_f.irq, 1'b0);

      // pads held high through reset release: no spurious capture
      reset_n = 1'b1;
      tick(6);
      bus_read(2'd3, rf, ra);
      check("arm_ecap_any",  ra, 4'h0);
      check("arm_ecap_fall", rf, 4'h0);

      // DATA path latency
      in_port = 4'hA;
      tick(3);
      bus_read(2'd0, rf, ra);
      check("data_A_fall", rf, 4'hA);
      check("data_A_any",  ra, 4'hA);
      bus_read(2'd3, rf, ra);
      check("ecap_FtoA_fall", rf, 4'h5);
      check("ecap_FtoA_any",  ra, 4'h5);
      bus_write(2'd0, 4'h3);
      bus_read(2'd0, rf, ra);
      check("data_ro", rf, 4'hA);
      bus_read(2'd1, rf, ra);
      check("addr1_zero", rf, 4'h0);
      bus_write(2'd3, 4'hF);
      bus_read(2'd3, rf, ra);
      check("w1c_all_fall", rf, 4'h0);
      check("w1c_all_any",  ra, 4'h0);

      // rising edges only seen by the any-edge instance
      in_port = 4'hF;
      tick(3);
      bus_read(2'd3, rf, ra);
      check("rise_fall_inst", rf, 4'h0);
      check("rise_any_inst",  ra, 4'h5);
      bus_write(2'd3, 4'hF);

      // F -> E captures bit0, then W1C clears it
      in_port = 4'hE;
      tick(3);
      bus_read(2'd3, rf, ra);
      check("ecap_E_fall", rf, 4'h1);
      check("ecap_E_any",  ra, 4'h1);
      bus_write(2'd3, 4'h1);
      bus_read(2'd3, rf, ra);
      check("ecap_clr_fall", rf, 4'h0);
      check("ecap_clr_any",  ra, 4'h0);

      // edge landing in the same cycle as its clear stays set
      in_port = 4'hF;
      tick(3);
      bus_write(2'd3, 4'hF);
      in_port = 4'hE;
      tick(2);
      bus_write(2'd3, 4'h1);
      bus_read(2'd3, rf, ra);
      check("edge_wins_fall", rf, 4'h1);
      check("edge_wins_any",  ra, 4'h1);

      // interrupt masking and timing
      bus_write(2'd3, 4'hF);
      bus_write(2'd2, 4'h1);
      bus_read(2'd2, rf, ra);
      check("irqmask_rd", rf, IRQ_EN ? 4'h1 : 4'h0);
      in_port = 4'hF;
      tick(4);
      bus_write(2'd3, 4'hF);
      tick(2);
      check("irq_idle", bus_f.irq, 1'b0);
      in_port = 4'hD;
      tick(4);
      check("irq_unmasked_bit1", bus_f.irq, 1'b0);
      bus_read(2'd3, rf, ra);
      check("ecap_bit1", rf, 4'h2);
      in_port = 4'hC;
      tick(3);
      check("irq_before_rise", bus_f.irq, 1'b0);
      tick(1);
      check("irq_rise", bus_f.irq, IRQ_EN);
      bus_write(2'd3, 4'hF);
      tick(1);
      check("irq_cleared", bus_f.irq, 1'b0);

      // reset in the middle of a pending read
      in_port = 4'hF;
      tick(4);
      bus_write(2'd3, 4'hF);
      in_port = 4'hC;
      tick(4);
      bus_read(2'd3, rf, ra);
      check("ecap_3_fall", rf, 4'h3);
      address = 2'd3; cs = 1'b1; rd_n = 1'b0; reset_n = 1'b0;
      tick(1);
      cs = 1'b0; rd_n = 1'b1;
      check("midrst_rd",  bus_f.readdata, 4'h0);
      check("midrst_irq", bus_f.irq, 1'b0);
      tick(1);
      reset_n = 1'b1;
      tick(6);
      bus_read(2'd3, rf, ra);
      check("post_rst_ecap", rf, 4'h0);
      bus_read(2'd2, rf, ra);
      check("post_rst_mask", rf, 4'h0);
      bus_read(2'd0, rf, ra);
      check("post_rst_data", rf, 4'hC);
      tick(2);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
